// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus for the fetch (pc) and load/store (ldst) ports.
// The CPU is the master and the memory responder is the slave.
interface cpu_mem_responder_if;
    logic [15:0] i_pc_addr;
    logic        i_pc_rd;
    logic [15:0] o_pc_rddata;
    logic [15:0] i_ldst_addr;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_wrdata;
    logic [15:0] o_ldst_rddata;
    logic [15:0] o_led;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    modport master (
        output i_pc_addr, i_pc_rd, i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
        input  o_pc_rddata, o_ldst_rddata, o_led, o_err, o_err_cnt
    );

    modport slave (
        input  i_pc_addr, i_pc_rd, i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
        output o_pc_rddata, o_ldst_rddata, o_led, o_err, o_err_cnt
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Shared word RAM plus LED / cycle-counter MMIO behind the CPU's fetch and
// load/store ports; registered read data, sticky error flag and error counter.
module cpu_mem_responder #(
    parameter int          DEPTH     = 4096,
    parameter string       INIT_FILE = "",
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input logic                clk,
    input logic                reset,
    cpu_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_LED,
        RGN_CNT,
        RGN_ILL
    } region_e;

    function automatic region_e decode(input logic [15:0] addr);
        logic [15:0] a;
        a = {addr[15:1], 1'b0};
        if (32'(a) < 32'(2 * DEPTH))          return RGN_RAM;
        else if (a == MMIO_BASE)              return RGN_LED;
        else if (a == MMIO_BASE + 16'd2)      return RGN_CNT;
        else                                  return RGN_ILL;
    endfunction

    logic [15:0] mem_q [DEPTH];

    logic [15:0] pc_rddata_q,   pc_rddata_d;
    logic [15:0] ldst_rddata_q, ldst_rddata_d;
    logic [15:0] led_q;
    logic [15:0] cnt_q;
    logic        err_q;
    logic [7:0]  err_cnt_q,     err_cnt_d;

    region_e     pc_rgn, ldst_rgn;
    logic [AW-1:0] pc_idx, ldst_idx;
    logic        ldst_req;
    logic        ram_wr;
    logic        led_wr;
    logic        pc_ill, ldst_ill;
    logic [8:0]  err_sum;

    assign pc_rgn   = decode(bus.i_pc_addr);
    assign ldst_rgn = decode(bus.i_ldst_addr);
    assign pc_idx   = bus.i_pc_addr[AW:1];
    assign ldst_idx = bus.i_ldst_addr[AW:1];
    assign ldst_req = bus.i_ldst_rd | bus.i_ldst_wr;
    assign ram_wr   = bus.i_ldst_wr && (ldst_rgn == RGN_RAM);
    assign led_wr   = bus.i_ldst_wr && (ldst_rgn == RGN_LED);
    assign pc_ill   = bus.i_pc_rd && (pc_rgn == RGN_ILL);
    assign ldst_ill = ldst_req && (ldst_rgn == RGN_ILL);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_rddata_d = 16'h0000;
        unique case (pc_rgn)
            // A store to the same word in this cycle is forwarded to the fetch.
            RGN_RAM: pc_rddata_d = (ram_wr && (ldst_idx == pc_idx)) ? bus.i_ldst_wrdata
                                                                     : mem_q[pc_idx];
            RGN_LED: pc_rddata_d = led_q;
            RGN_CNT: pc_rddata_d = cnt_q;
            default: pc_rddata_d = 16'h0000;
        endcase
    end

    // The ldst port reads the pre-write contents (read-before-write).
    always_comb begin
        ldst_rddata_d = 16'h0000;
        unique case (ldst_rgn)
            RGN_RAM: ldst_rddata_d = mem_q[ldst_idx];
            RGN_LED: ldst_rddata_d = led_q;
            RGN_CNT: ldst_rddata_d = cnt_q;
            default: ldst_rddata_d = 16'h0000;
        endcase
    end

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 9'(pc_ill) + 9'(ldst_ill);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // NOTE: the RAM array has no reset; clearing thousands of words is neither required nor mappable to block RAM.
    always_ff @(posedge clk) begin
        if (ram_wr) mem_q[ldst_idx] <= bus.i_ldst_wrdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_rddata_q   <= '0;
            ldst_rddata_q <= '0;
            led_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
            if (bus.i_pc_rd)   pc_rddata_q   <= pc_rddata_d;
            if (bus.i_ldst_rd) ldst_rddata_q <= ldst_rddata_d;
            if (led_wr)        led_q         <= bus.i_ldst_wrdata;
            if (pc_ill || ldst_ill) begin
                err_q     <= 1'b1;
                err_cnt_q <= err_cnt_d;
            end
        end
    end

    assign bus.o_pc_rddata   = pc_rddata_q;
    assign bus.o_ldst_rddata = ldst_rddata_q;
    assign bus.o_led         = led_q;
    assign bus.o_err         = err_q;
    assign bus.o_err_cnt     = err_cnt_q;
endmodule
